sign_classifier: RTL and testbench
==================================

SIGN_CLASSIFIER -- requirements
Module: sign_classifier

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits (two's complement), legal range 2..64.
REQ-002 Parameter NCH, default 4, number of independent channels, legal range 1..16.
REQ-003 Parameter DEBOUNCE, default 2, consecutive agreeing valid samples needed to change a channel's class, legal range 1..15.
REQ-004 Parameter CNT_W, default 8, width of each per-channel class-change counter, legal range 1..16.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  reset, asynchronous and active-high.
REQ-007 Port in_valid  input  1  in_data holds a sample vector this cycle.
REQ-008 Port in_data  input  NCH*WIDTH  samples; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port clear  input  1  synchronous clear of all change counters.
REQ-010 Port pos_flag  output  NCH  bit k high: channel k committed class is POSITIVE.
REQ-011 Port neg_flag  output  NCH  bit k high: channel k committed class is NEGATIVE.
REQ-012 Port zero_flag  output  NCH  bit k high: channel k committed class is ZERO.
REQ-013 Port out_valid  output  1  flags reflect a sample accepted on the previous edge.
REQ-014 Port change_pulse  output  NCH  bit k high for one cycle when channel k commits a new class.
REQ-015 Port change_cnt  output  NCH*CNT_W  per-channel saturating commit counters, packed like in_data.

Function
REQ-016 Raw class of a sample SHALL be NEGATIVE if MSB=1, ZERO if all bits 0, else POSITIVE; most-negative value is NEGATIVE.
REQ-017 Each channel SHALL hold: committed class, candidate class, and run counter of width clog2(DEBOUNCE+1).
REQ-018 For each channel, when in_valid=1 and raw class equals committed class, run SHALL clear to 0 and candidate is don't-care.
REQ-019 When in_valid=1, raw class differs from committed, and equals candidate with run>0, run SHALL increment.
REQ-020 When in_valid=1, raw class differs from committed, and differs from candidate or run=0, candidate SHALL load raw class and run SHALL load 1.
REQ-021 When the updated run value equals DEBOUNCE, committed SHALL load the candidate and run SHALL clear on the same edge; with DEBOUNCE=1 every differing sample commits immediately.
REQ-022 When in_valid=0, committed, candidate and run SHALL hold and change_pulse SHALL be 0.
REQ-023 pos_flag/neg_flag/zero_flag SHALL be registered, exactly one bit of the three set per channel at all times, updating on the edge that accepts the committing sample (latency one cycle from input).
REQ-024 out_valid SHALL be in_valid delayed by one cycle.
REQ-025 change_pulse[k] SHALL be high for exactly the cycle following a commit on channel k, coincident with the new flag values.
REQ-026 change_cnt[k] SHALL increment on each commit and saturate at 2^CNT_W-1.
REQ-027 clear=1 SHALL set all counters to 0 on that edge, taking priority over a simultaneous commit; flags and debounce state are unaffected by clear.
REQ-028 Channels SHALL be fully independent; simultaneous commits on several channels SHALL each pulse and count.

Reset
REQ-029 On rst=1, asynchronously: committed class ZERO (zero_flag all ones, pos_flag=neg_flag=0), run=0, candidate ZERO, out_valid=0, change_pulse=0, change_cnt=0.
REQ-030 Reset asserted mid-debounce SHALL discard the partial run; first sample after release starts a fresh run.
REQ-031 Outputs SHALL hold reset values until the first accepted sample after rst deasserts.

Verification (WIDTH=16, NCH=4, DEBOUNCE=2, CNT_W=8)
REQ-032 Reset release, ch0 in=0x0005 valid one cycle -> no commit, zero_flag[0]=1; second consecutive 0x0005 -> next cycle pos_flag[0]=1, change_pulse[0]=1, change_cnt[0]=1.
REQ-033 Ch1 committed POSITIVE, samples 0x8000, 0x0003, 0x8000 -> no commit (run restarts); then 0x8000 again -> neg_flag[1]=1, change_pulse[1]=1.
REQ-034 Ch2 alternating 0x0001/0x0000 pairs 300 times -> change_cnt[2] saturates at 255, no wrap.
REQ-035 Commit on ch3 with clear=1 in same cycle -> change_cnt[3]=0, flags still update, change_pulse[3]=1.
REQ-036 One 0xFFFF sample on ch0 then rst pulse then one 0xFFFF -> no commit; a second 0xFFFF -> neg_flag[0]=1.
REQ-037 in_valid gapped (valid, idle 3 cycles, valid) with matching NEGATIVE samples -> commit after second valid; out_valid tracks in_valid by one cycle.

Source files
------------

// File: rtl/sign_classifier.sv
// Per-channel sign classifier with debounced class commits, one-hot class flags
// and saturating per-channel commit counters.
module sign_classifier #(
    parameter int WIDTH    = 16,
    parameter int NCH      = 4,
    parameter int DEBOUNCE = 2,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic                   clear,
    output logic [NCH-1:0]         pos_flag,
    output logic [NCH-1:0]         neg_flag,
    output logic [NCH-1:0]         zero_flag,
    output logic                   out_valid,
    output logic [NCH-1:0]         change_pulse,
    output logic [NCH*CNT_W-1:0]   change_cnt
);

    localparam int RW = $clog2(DEBOUNCE + 1);

    // Classes are one-hot so the committed class register doubles as the flag register.
    localparam logic [2:0]       CLS_POS  = 3'b001;
    localparam logic [2:0]       CLS_ZERO = 3'b010;
    localparam logic [2:0]       CLS_NEG  = 3'b100;
    localparam logic [RW-1:0]    RUN_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0]    RUN_ONE  = RW'(1);
    localparam logic [RW-1:0]    RUN_DONE = RW'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic [2:0] raw_class(input logic [WIDTH-1:0] sample);
        logic [2:0] cls;
        if (sample[WIDTH-1]) begin
            cls = CLS_NEG;
        end else if (sample == {WIDTH{1'b0}}) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_POS;
        end
        return cls;
    endfunction

    logic [2:0]       comm_r    [NCH];
    logic [2:0]       cand_r    [NCH];
    logic [RW-1:0]    run_r     [NCH];
    logic [CNT_W-1:0] cnt_r     [NCH];
    logic [NCH-1:0]   pulse_r;
    logic             out_valid_r;

    logic [2:0]       raw_s     [NCH];
    logic [2:0]       comm_s    [NCH];
    logic [2:0]       cand_s    [NCH];
    logic [RW-1:0]    run_s     [NCH];
    logic [RW-1:0]    run_try_s [NCH];
    logic [NCH-1:0]   commit_s;

    // Debounce next-state: track a candidate class and commit after DEBOUNCE agreeing samples.
    always_comb begin
        commit_s = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            raw_s[k]     = raw_class(in_data[k*WIDTH +: WIDTH]);
            comm_s[k]    = comm_r[k];
            cand_s[k]    = cand_r[k];
            run_s[k]     = run_r[k];
            run_try_s[k] = run_r[k];
            if (in_valid) begin
                if (raw_s[k] == comm_r[k]) begin
                    run_try_s[k] = RUN_ZERO;
                end else if ((raw_s[k] == cand_r[k]) && (run_r[k] != RUN_ZERO)) begin
                    run_try_s[k] = run_r[k] + RUN_ONE;
                end else begin
                    cand_s[k]    = raw_s[k];
                    run_try_s[k] = RUN_ONE;
                end
                if (run_try_s[k] == RUN_DONE) begin
                    comm_s[k]   = cand_s[k];
                    run_s[k]    = RUN_ZERO;
                    commit_s[k] = 1'b1;
                end else begin
                    run_s[k] = run_try_s[k];
                end
            end else begin
                run_s[k] = run_r[k];
            end
        end
    end

    // State, flag, pulse and counter registers; clear outranks a same-edge commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                comm_r[k] <= CLS_ZERO;
                cand_r[k] <= CLS_ZERO;
                run_r[k]  <= RUN_ZERO;
                cnt_r[k]  <= CNT_ZERO;
            end
            pulse_r     <= {NCH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                comm_r[k] <= comm_s[k];
                cand_r[k] <= cand_s[k];
                run_r[k]  <= run_s[k];
                if (clear) begin
                    cnt_r[k] <= CNT_ZERO;
                end else if (commit_s[k] && (cnt_r[k] != CNT_MAX)) begin
                    cnt_r[k] <= cnt_r[k] + CNT_ONE;
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
            pulse_r     <= commit_s;
            out_valid_r <= in_valid;
        end
    end

    // Unpack the per-channel registers onto the flat output ports.
    always_comb begin
        pos_flag   = {NCH{1'b0}};
        zero_flag  = {NCH{1'b0}};
        neg_flag   = {NCH{1'b0}};
        change_cnt = {(NCH*CNT_W){1'b0}};
        for (int k = 0; k < NCH; k++) begin
            pos_flag[k]                  = comm_r[k][0];
            zero_flag[k]                 = comm_r[k][1];
            neg_flag[k]                  = comm_r[k][2];
            change_cnt[k*CNT_W +: CNT_W] = cnt_r[k];
        end
    end

    assign out_valid    = out_valid_r;
    assign change_pulse = pulse_r;

endmodule

// File: tb/tb_sign_classifier.sv
// Bench for sign_classifier: directed vector table, hand-written corner sequences
// and randomized traffic checked against a history-based reference model.
module tb_sign_classifier;

    localparam int WIDTH    = 16;
    localparam int NCH      = 4;
    localparam int DEBOUNCE = 2;
    localparam int CNT_W    = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 clear;
    logic [NCH-1:0]       pos_flag, neg_flag, zero_flag, change_pulse;
    logic                 out_valid;
    logic [NCH*CNT_W-1:0] change_cnt;

    sign_classifier #(.WIDTH(WIDTH), .NCH(NCH), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .pos_flag(pos_flag), .neg_flag(neg_flag), .zero_flag(zero_flag),
        .out_valid(out_valid), .change_pulse(change_pulse), .change_cnt(change_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: committed class as -1/0/+1 and the raw classes seen since the last commit.
    int             m_comm [NCH];
    int             m_cnt  [NCH];
    int             hist   [NCH][$];
    logic [NCH-1:0] m_pulse;
    logic           m_ov;

    function automatic int sign_of(input logic [WIDTH-1:0] s);
        if ($signed(s) < 0) return -1;
        else if (s == 16'h0000) return 0;
        else return 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_comm[k] = 0;
            m_cnt[k]  = 0;
            hist[k].delete();
        end
        m_pulse = '0;
        m_ov    = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [NCH*WIDTH-1:0] d, input logic c);
        m_ov    = v;
        m_pulse = '0;
        for (int k = 0; k < NCH; k++) begin
            bit commit;
            int r;
            commit = 0;
            if (v) begin
                r = sign_of(d[k*WIDTH +: WIDTH]);
                hist[k].push_back(r);
                if (hist[k].size() > DEBOUNCE) void'(hist[k].pop_front());
                if (hist[k].size() == DEBOUNCE && r != m_comm[k]) begin
                    commit = 1;
                    foreach (hist[k][j]) if (hist[k][j] != r) commit = 0;
                end
                if (commit) begin
                    m_comm[k]  = r;
                    m_pulse[k] = 1'b1;
                    hist[k].delete();
                end
            end
            if (c) m_cnt[k] = 0;
            else if (commit && m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [NCH-1:0]       e_pos, e_neg, e_zero;
        logic [NCH*CNT_W-1:0] e_cnt;
        for (int k = 0; k < NCH; k++) begin
            e_pos[k]                = (m_comm[k] == 1);
            e_neg[k]                = (m_comm[k] == -1);
            e_zero[k]               = (m_comm[k] == 0);
            e_cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
        end
        check_eq({tag, "_pos"},   64'(pos_flag),     64'(e_pos));
        check_eq({tag, "_neg"},   64'(neg_flag),     64'(e_neg));
        check_eq({tag, "_zero"},  64'(zero_flag),    64'(e_zero));
        check_eq({tag, "_pulse"}, 64'(change_pulse), 64'(m_pulse));
        check_eq({tag, "_cnt"},   64'(change_cnt),   64'(e_cnt));
        check_eq({tag, "_ov"},    64'(out_valid),    64'(m_ov));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next one.
    task automatic step(input logic v, input logic [NCH*WIDTH-1:0] d, input logic c, input string tag);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        model_edge(v, d, c);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        rst      = 1'b1;
        model_reset();
        #2;
        check_model("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_model("rst_hold");
    endtask

    typedef struct {
        logic                 v;
        logic [NCH*WIDTH-1:0] d;
        logic                 c;
        logic [NCH-1:0]       pos, neg, zero, pulse;
        logic                 ov;
        logic [NCH*CNT_W-1:0] cnt;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [NCH*WIDTH-1:0] d;
        in_valid = 1'b0;
        in_data  = '0;
        clear    = 1'b0;
        rst      = 1'b0;

        tbl[0]  = '{1'b1, 64'h0000_0000_0000_0005, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 32'h0000_0000};
        tbl[1]  = '{1'b1, 64'h0000_0000_0000_0005, 1'b0, 4'h1, 4'h0, 4'hE, 4'h1, 1'b1, 32'h0000_0001};
        tbl[2]  = '{1'b1, 64'h0000_0000_0003_0005, 1'b0, 4'h1, 4'h0, 4'hE, 4'h0, 1'b1, 32'h0000_0001};
        tbl[3]  = '{1'b1, 64'h0000_0000_0003_0005, 1'b0, 4'h3, 4'h0, 4'hC, 4'h2, 1'b1, 32'h0000_0101};
        tbl[4]  = '{1'b1, 64'h0000_0000_8000_0005, 1'b0, 4'h3, 4'h0, 4'hC, 4'h0, 1'b1, 32'h0000_0101};
        tbl[5]  = '{1'b1, 64'h0000_0000_0003_0005, 1'b0, 4'h3, 4'h0, 4'hC, 4'h0, 1'b1, 32'h0000_0101};
        tbl[6]  = '{1'b1, 64'h0000_0000_8000_0005, 1'b0, 4'h3, 4'h0, 4'hC, 4'h0, 1'b1, 32'h0000_0101};
        tbl[7]  = '{1'b1, 64'h0000_0000_8000_0005, 1'b0, 4'h1, 4'h2, 4'hC, 4'h2, 1'b1, 32'h0000_0201};
        tbl[8]  = '{1'b1, 64'h0000_0000_8000_FFFF, 1'b0, 4'h1, 4'h2, 4'hC, 4'h0, 1'b1, 32'h0000_0201};
        tbl[9]  = '{1'b0, 64'h0000_0000_0000_0000, 1'b0, 4'h1, 4'h2, 4'hC, 4'h0, 1'b0, 32'h0000_0201};
        tbl[10] = '{1'b0, 64'h0000_0000_0000_0000, 1'b0, 4'h1, 4'h2, 4'hC, 4'h0, 1'b0, 32'h0000_0201};
        tbl[11] = '{1'b0, 64'h0000_0000_0000_0000, 1'b0, 4'h1, 4'h2, 4'hC, 4'h0, 1'b0, 32'h0000_0201};
        tbl[12] = '{1'b1, 64'h0000_0000_8000_FFFF, 1'b0, 4'h0, 4'h3, 4'hC, 4'h1, 1'b1, 32'h0000_0202};
        tbl[13] = '{1'b1, 64'h7000_0000_8000_FFFF, 1'b0, 4'h0, 4'h3, 4'hC, 4'h0, 1'b1, 32'h0000_0202};
        tbl[14] = '{1'b1, 64'h7000_0000_8000_FFFF, 1'b1, 4'h8, 4'h3, 4'h4, 4'h8, 1'b1, 32'h0000_0000};

        #1;
        do_reset();
        check_eq("reset_zero_flag", 64'(zero_flag), 64'hF);
        step(1'b0, '0, 1'b0, "idle_after_rst");

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c, $sformatf("t%0d_model", i));
            check_eq($sformatf("t%0d_pos", i),   64'(pos_flag),     64'(tbl[i].pos));
            check_eq($sformatf("t%0d_neg", i),   64'(neg_flag),     64'(tbl[i].neg));
            check_eq($sformatf("t%0d_zero", i),  64'(zero_flag),    64'(tbl[i].zero));
            check_eq($sformatf("t%0d_pulse", i), 64'(change_pulse), 64'(tbl[i].pulse));
            check_eq($sformatf("t%0d_ov", i),    64'(out_valid),    64'(tbl[i].ov));
            check_eq($sformatf("t%0d_cnt", i),   64'(change_cnt),   64'(tbl[i].cnt));
        end

        // Reset in the middle of a debounce run discards the partial run.
        do_reset();
        step(1'b1, 64'h0000_0000_0000_FFFF, 1'b0, "rd_a");
        do_reset();
        step(1'b1, 64'h0000_0000_0000_FFFF, 1'b0, "rd_b");
        check_eq("rstdeb_no_commit", 64'(neg_flag[0]), 64'h0);
        step(1'b1, 64'h0000_0000_0000_FFFF, 1'b0, "rd_c");
        check_eq("rstdeb_commit", 64'(neg_flag[0]), 64'h1);
        check_eq("rstdeb_pulse", 64'(change_pulse), 64'h1);

        // Counter saturation on channel 2: 300 commits against an 8-bit counter.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            d = '0;
            d[2*WIDTH +: WIDTH] = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            step(1'b1, d, 1'b0, "sat");
            step(1'b1, d, 1'b0, "sat");
            if (i == 254) check_eq("sat_reach", 64'(change_cnt[2*CNT_W +: CNT_W]), 64'hFF);
        end
        check_eq("sat_hold", 64'(change_cnt[2*CNT_W +: CNT_W]), 64'hFF);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            for (int k = 0; k < NCH; k++) begin
                case ($urandom_range(0, 5))
                    0: d[k*WIDTH +: WIDTH] = 16'h0000;
                    1: d[k*WIDTH +: WIDTH] = 16'h0001;
                    2: d[k*WIDTH +: WIDTH] = 16'h7FFF;
                    3: d[k*WIDTH +: WIDTH] = 16'h8000;
                    4: d[k*WIDTH +: WIDTH] = 16'hFFFF;
                    default: d[k*WIDTH +: WIDTH] = 16'($urandom);
                endcase
            end
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 31) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
